// File: rtl/fifo_rr_arbiter_if.sv
// Signal bundle between fifo_rr_arbiter, the FIFO read ports it drains, and
// the downstream consumer of the merged stream.
interface fifo_rr_arbiter_if #(
    parameter int WIDTH  = 32,
    parameter int NUM_CH = 4,
    parameter int CH_LOG = $clog2(NUM_CH)
);
    logic [NUM_CH-1:0]       CH_EMPTY;
    logic [NUM_CH-1:0]       CH_RD_EN;
    logic [NUM_CH*WIDTH-1:0] CH_RD_DATA;
    logic [NUM_CH-1:0]       CH_RD_VALID;
    logic [WIDTH-1:0]        OUT_DATA;
    logic [CH_LOG-1:0]       OUT_CH;
    logic                    OUT_VALID;
    logic                    OUT_READY;
    logic                    BUSY;

    // Arbiter side.
    modport master (
        input  CH_EMPTY, CH_RD_DATA, CH_RD_VALID, OUT_READY,
        output CH_RD_EN, OUT_DATA, OUT_CH, OUT_VALID, BUSY
    );

    // FIFO / consumer side.
    modport slave (
        output CH_EMPTY, CH_RD_DATA, CH_RD_VALID, OUT_READY,
        input  CH_RD_EN, OUT_DATA, OUT_CH, OUT_VALID, BUSY
    );
endinterface

// File: rtl/fifo_rr_arbiter.sv
// Round-robin burst arbiter over NUM_CH standard-mode FIFO read ports.
// A channel is granted for up to MAX_BURST reads; returned words are merged
// into a 2-entry output buffer tagged with their source channel. Reads are
// throttled so buffered plus in-flight words never exceed the buffer depth.
module fifo_rr_arbiter #(
    parameter int WIDTH     = 32,
    parameter int NUM_CH    = 4,
    parameter int MAX_BURST = 8,
    parameter int CH_LOG    = $clog2(NUM_CH)
) (
    input  logic              CLK,
    input  logic              RST,
    fifo_rr_arbiter_if.master bus
);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state;
    logic [CH_LOG-1:0] ptr;
    logic [CH_LOG-1:0] g;
    logic [CNT_W-1:0]  burst_cnt;
    logic              inflight;

    logic [1:0]        occ;
    logic [WIDTH-1:0]  head_data;
    logic [CH_LOG-1:0] head_ch;
    logic [WIDTH-1:0]  tail_data;
    logic [CH_LOG-1:0] tail_ch;

    logic [WIDTH-1:0]  ch_word [NUM_CH];
    logic [NUM_CH-1:0] rd_en;
    logic [CH_LOG-1:0] cand;
    logic [CH_LOG-1:0] next_ch;
    logic [CH_LOG-1:0] next_ptr;
    logic [2:0]        load;
    logic              found;
    logic              g_empty;
    logic              pop;
    logic              push;
    logic              issue;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
        assign ch_word[k] = bus.CH_RD_DATA[k*WIDTH +: WIDTH];
    end

    assign g_empty  = bus.CH_EMPTY[g];
    assign pop      = (occ != 2'd0) && bus.OUT_READY;
    assign push     = inflight && bus.CH_RD_VALID[g];
    assign load     = {1'b0, occ} + {2'b00, inflight};
    // A new read is allowed only if, after this cycle's pop, at most one slot
    // is spoken for; the word it returns then always has room.
    assign issue    = (state == BURST) && !g_empty && (load <= 3'd1 + {2'b00, pop});
    assign next_ptr = (g == CH_LOG'(NUM_CH - 1)) ? '0 : g + 1'b1;

    // Rotating search for the first non-empty channel starting at ptr.
    always_comb begin
        // NOTE: every variable gets a default before any conditional update,
        // otherwise an unassigned path turns it into a latch.
        found   = 1'b0;
        next_ch = ptr;
        cand    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = CH_LOG'((int'(ptr) + i) % NUM_CH);
            if (!found && !bus.CH_EMPTY[cand]) begin
                found   = 1'b1;
                next_ch = cand;
            end
        end
    end

    // Read enable goes only to the granted channel.
    always_comb begin
        rd_en = '0;
        if (issue) rd_en[g] = 1'b1;
    end

    // Grant FSM: pick a channel, read up to MAX_BURST words, wait out the last read.
    always_ff @(posedge CLK or posedge RST) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (RST) begin
            state     <= IDLE;
            ptr       <= '0;
            g         <= '0;
            burst_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        g         <= next_ch;
                        burst_cnt <= '0;
                        state     <= BURST;
                    end
                end
                BURST: begin
                    if (issue) begin
                        burst_cnt <= burst_cnt + 1'b1;
                        if (burst_cnt == CNT_W'(MAX_BURST - 1)) state <= DRAIN;
                    end else if (g_empty) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!inflight) begin
                        ptr   <= next_ptr;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A read issued last cycle is in flight for exactly one cycle, data or not.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) inflight <= 1'b0;
        else     inflight <= issue;
    end

    // Two-entry output FIFO; head drives OUT_DATA/OUT_CH directly.
    always_ff @(posedge CLK or posedge RST) begin
        // NOTE: the buffer entries are reset too, since the head is a visible
        // output that must read zero while RST is high.
        if (RST) begin
            occ       <= 2'd0;
            head_data <= '0;
            head_ch   <= '0;
            tail_data <= '0;
            tail_ch   <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) begin
                        head_data <= ch_word[g];
                        head_ch   <= g;
                    end else begin
                        tail_data <= ch_word[g];
                        tail_ch   <= g;
                    end
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    head_data <= tail_data;
                    head_ch   <= tail_ch;
                    occ       <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        head_data <= ch_word[g];
                        head_ch   <= g;
                    end else begin
                        head_data <= tail_data;
                        head_ch   <= tail_ch;
                        tail_data <= ch_word[g];
                        tail_ch   <= g;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.CH_RD_EN  = rd_en;
    assign bus.OUT_DATA  = head_data;
    assign bus.OUT_CH    = head_ch;
    assign bus.OUT_VALID = (occ != 2'd0);
    assign bus.BUSY      = (state != IDLE);
endmodule
